// File: rtl/dlx_bp_pkg.sv
// Shared definitions for the DLX branch predictor: 2-bit counter encodings,
// id_ctrl bit positions, FSM state type and the saturating counter update.
package dlx_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam int CTRL_BR = 1;
  localparam int CTRL_EQ = 0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
    ctr_e n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Branch history table: ENTRIES 2-bit counters, one async read port and one
// sync write port that either loads WNT (init sweep) or applies a saturating step.
module bp_counter_table
  import dlx_bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_e             rd_ctr,
  input  logic             wr_en,
  input  logic             wr_init,
  input  logic             wr_taken,
  input  logic [IDX_W-1:0] wr_idx
);

  ctr_e mem_q [ENTRIES];

  // Read is unbypassed: a same-cycle write is only visible next cycle.
  assign rd_ctr = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_init ? WNT : ctr_update(mem_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with power-up table sweep and registered mispredict.
// Optional BP_STATS_EN adds saturating branch / mispredict counters.
module branch_predict_unit
  import dlx_bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            id_valid,
  input  logic            id_stall,
  input  logic [PC_W-1:0] id_pc,
  input  logic [1:0]      id_ctrl,
  input  logic            id_cmp,
  input  logic            id_pred_taken,
  output logic            PC_sel,
  output logic            mispredict,
  output logic            redirect_taken,
  output logic            init_done
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             mispredict_q, mispredict_d;
  logic             redirect_q, redirect_d;
  logic             resolve, br_update, tbl_init, tbl_we;
  logic [IDX_W-1:0] rd_idx, id_idx, tbl_widx;
  ctr_e             rd_ctr;
  logic             unused_pc_bits;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

  assign PC_sel     = id_ctrl[CTRL_BR] & ~(id_ctrl[CTRL_EQ] ^ id_cmp);
  assign init_done  = (state_q == RUN);
  assign resolve    = id_valid & ~id_stall & init_done;
  assign br_update  = resolve & id_ctrl[CTRL_BR];
  assign pred_taken = if_valid & init_done & rd_ctr[1];

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    tbl_init = 1'b0;
    case (state_q)
      INIT: begin
        tbl_init = 1'b1;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
      end
      RUN: state_d = RUN;
    endcase
  end

  assign tbl_we       = tbl_init | br_update;
  assign tbl_widx     = tbl_init ? sweep_q : id_idx;
  assign mispredict_d = resolve & (PC_sel ^ id_pred_taken);
  assign redirect_d   = resolve & PC_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign mispredict     = mispredict_q;
  assign redirect_taken = redirect_q;

  bp_counter_table #(.ENTRIES(ENTRIES)) u_table (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (tbl_we),
    .wr_init  (tbl_init),
    .wr_taken (PC_sel),
    .wr_idx   (tbl_widx)
  );

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (br_update && (stat_br_q != '1))    stat_br_q <= stat_br_q + 32'd1;
      if (mispredict_d && (stat_mp_q != '1)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expected values
// tagged with the cycle they are due; a negedge monitor compares them.
module tb_branch_predict_unit;

  localparam int K_INIT  = 0;
  localparam int K_PRED  = 1;
  localparam int K_PCSEL = 2;
  localparam int K_MISP  = 3;
  localparam int K_REDIR = 4;
  localparam int K_SB    = 5;
  localparam int K_SM    = 6;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid, id_valid, id_stall, id_cmp, id_pred_taken;
  logic [31:0] if_pc, id_pc;
  logic [1:0]  id_ctrl;
  logic        pred_taken, PC_sel, mispredict, redirect_taken, init_done;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;
  sb_t sb[$];

  branch_predict_unit #(.ENTRIES(64), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .id_pc          (id_pc),
    .id_ctrl        (id_ctrl),
    .id_cmp         (id_cmp),
    .id_pred_taken  (id_pred_taken),
    .PC_sel         (PC_sel),
    .mispredict     (mispredict),
    .redirect_taken (redirect_taken),
    .init_done      (init_done)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_INIT:  return "init_done";
      K_PRED:  return "pred_taken";
      K_PCSEL: return "PC_sel";
      K_MISP:  return "mispredict";
      K_REDIR: return "redirect_taken";
      K_SB:    return "stat_branches";
      default: return "stat_mispredicts";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_INIT:  return {31'd0, init_done};
      K_PRED:  return {31'd0, pred_taken};
      K_PCSEL: return {31'd0, PC_sel};
      K_MISP:  return {31'd0, mispredict};
      K_REDIR: return {31'd0, redirect_taken};
`ifdef BP_STATS_EN
      K_SB:    return stat_branches;
      K_SM:    return stat_mispredicts;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; overdue ones are failures.
  always @(negedge clk) begin : monitor
    sb_t         keep[$];
    logic [31:0] act;
    keep.delete();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > cyc) begin
        keep.push_back(sb[i]);
      end else begin
        act = sample(sb[i].kind);
        n_cmp++;
        if (sb[i].cyc != cyc || act !== sb[i].val) begin
          n_err++;
          $display("FAIL %s @cycle %0d: got %0h, expected %0h (due cycle %0d)",
                   kname(sb[i].kind), cyc, act, sb[i].val, sb[i].cyc);
        end
      end
    end
    sb = keep;
  end

  task automatic sb_push(input int kind, input int d, input logic [31:0] v);
    sb.push_back('{cyc: cyc + d, kind: kind, val: v});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; if_pc = 0; id_valid = 0; id_stall = 0;
    id_pc = 0; id_ctrl = 2'b00; id_cmp = 0; id_pred_taken = 0;
  endtask

  task automatic resolve_in(input logic [31:0] pc, input logic [1:0] ctrl,
                            input logic cmp, input logic pt, input logic stall);
    id_valid = 1; id_stall = stall; id_pc = pc;
    id_ctrl = ctrl; id_cmp = cmp; id_pred_taken = pt;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_pred);
    if_valid = 1; if_pc = pc;
    sb_push(K_PRED, 0, {31'd0, exp_pred});
  endtask

  initial begin
    idle();
    rst = 1;
    nxt(); nxt();
    rst = 0;
    // Power-up sweep: 64 INIT cycles, lookups blocked, resolves ignored.
    sb_push(K_INIT, 0, 0);
    sb_push(K_INIT, 63, 0);
    sb_push(K_INIT, 64, 1);
    sb_push(K_MISP, 0, 0);
    sb_push(K_REDIR, 0, 0);
`ifdef BP_STATS_EN
    sb_push(K_SB, 0, 0);
`endif
    for (int k = 0; k < 64; k++) begin
      idle();
      lookup(32'(k * 4), 1'b0);
      if (k == 40 || k == 41) begin
        resolve_in(32'h14, 2'b11, 1, 0, 0);
        sb_push(K_MISP, 1, 0);
      end
      nxt();
    end
    idle();
    lookup(32'h14, 1'b0);
    nxt();
    idle();
    lookup(32'h40, 1'b0);
    nxt();

    // beq taken twice at 0x40, same-cycle lookup sees pre-update value.
    for (int r = 0; r < 2; r++) begin
      idle();
      resolve_in(32'h40, 2'b11, 1, 0, 0);
      lookup(32'h40, r == 1);
      sb_push(K_PCSEL, 0, 1);
      sb_push(K_MISP, 1, 1);
      sb_push(K_REDIR, 1, 1);
      nxt();
    end
    idle();
    lookup(32'h40, 1'b1);
    sb_push(K_MISP, 1, 0);
    sb_push(K_REDIR, 1, 0);
    nxt();
    idle();
    if_pc = 32'h40;
    sb_push(K_PRED, 0, 0);
    nxt();

    // bne with equal operands: not taken, counter saturates at 0.
    for (int r = 0; r < 2; r++) begin
      idle();
      resolve_in(32'h80, 2'b10, 1, 0, 0);
      sb_push(K_PCSEL, 0, 0);
      sb_push(K_MISP, 1, 0);
      sb_push(K_REDIR, 1, 0);
      nxt();
    end
    idle();
    lookup(32'h80, 1'b0);
    nxt();
    for (int r = 0; r < 2; r++) begin
      idle();
      resolve_in(32'h80, 2'b10, 0, 0, 0);
      sb_push(K_PCSEL, 0, 1);
      sb_push(K_MISP, 1, 1);
      sb_push(K_REDIR, 1, 1);
      nxt();
      idle();
      lookup(32'h80, r == 1);
      nxt();
    end

    // Non-branch carrying a taken prediction: mispredict, no table write.
    idle();
    resolve_in(32'h80, 2'b00, 1, 1, 0);
    sb_push(K_PCSEL, 0, 0);
    sb_push(K_MISP, 1, 1);
    sb_push(K_REDIR, 1, 0);
    nxt();
    idle();
    resolve_in(32'h80, 2'b01, 1, 0, 0);
    sb_push(K_PCSEL, 0, 0);
    sb_push(K_MISP, 1, 0);
    nxt();
    idle();
    lookup(32'h80, 1'b1);
    nxt();

    // Stalled branch: no effect for 3 cycles, then exactly one update.
    for (int r = 0; r < 3; r++) begin
      idle();
      resolve_in(32'hC0, 2'b11, 1, 0, 1);
      lookup(32'hC0, 1'b0);
      sb_push(K_PCSEL, 0, 1);
      sb_push(K_MISP, 1, 0);
      sb_push(K_REDIR, 1, 0);
      nxt();
    end
    idle();
    resolve_in(32'hC0, 2'b11, 1, 0, 0);
    sb_push(K_MISP, 1, 1);
    sb_push(K_REDIR, 1, 1);
    nxt();
    idle();
    lookup(32'hC0, 1'b1);
    nxt();
    idle();
    resolve_in(32'hC0, 2'b10, 1, 0, 0);
    sb_push(K_MISP, 1, 0);
    nxt();
    idle();
    lookup(32'hC0, 1'b0);
`ifdef BP_STATS_EN
    sb_push(K_SB, 0, 8);
    sb_push(K_SM, 0, 6);
`endif
    nxt();

    // Reset in RUN over a mispredicting branch: outputs cleared, sweep restarts.
    idle();
    resolve_in(32'h40, 2'b11, 1, 0, 0);
    rst = 1;
    sb_push(K_MISP, 1, 0);
    sb_push(K_REDIR, 1, 0);
    sb_push(K_INIT, 1, 0);
    nxt();
    rst = 0;
    idle();
`ifdef BP_STATS_EN
    sb_push(K_SB, 0, 0);
    sb_push(K_SM, 0, 0);
`endif
    for (int k = 0; k < 30; k++) begin
      idle();
      lookup(32'h40, 1'b0);
      nxt();
    end
    // Reset again at sweep index 30.
    idle();
    rst = 1;
    nxt();
    rst = 0;
    sb_push(K_INIT, 0, 0);
    sb_push(K_INIT, 63, 0);
    sb_push(K_INIT, 64, 1);
    for (int k = 0; k < 64; k++) nxt();
    idle();
    lookup(32'h80, 1'b0);
    nxt();
    idle();
    lookup(32'h40, 1'b0);
    nxt();
    idle();

    for (int w = 0; w < 10 && sb.size() > 0; w++) nxt();
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 64, number of branch-history-table entries; SHALL be a power of two, >= 2.
REQ-002 Parameter PC_W, default 32, program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_valid  input  1  fetch-stage lookup request.
REQ-006 if_pc  input  PC_W  fetch PC to predict.
REQ-007 pred_taken  output  1  prediction for if_pc, combinational.
REQ-008 id_valid  input  1  decode-stage instruction valid.
REQ-009 id_stall  input  1  decode stage held; blocks all resolution effects.
REQ-010 id_pc  input  PC_W  PC of decode-stage instruction.
REQ-011 id_ctrl  input  2  [1] = branch, [0] = taken-on-equal (1 beq-style, 0 bne-style).
REQ-012 id_cmp  input  1  comparator result (operands equal).
REQ-013 id_pred_taken  input  1  prediction carried with the instruction from fetch.
REQ-014 PC_sel  output  1  actual taken, combinational.
REQ-015 mispredict  output  1  registered one-cycle pulse: prediction was wrong.
REQ-016 redirect_taken  output  1  registered actual outcome, valid with mispredict.
REQ-017 init_done  output  1  high once table initialisation is complete.

Function
REQ-018 PC_sel SHALL equal id_ctrl[1] & (id_ctrl[0] XNOR id_cmp), independent of id_valid.
REQ-019 Table: ENTRIES 2-bit saturating counters; index = if_pc[IDX_W+1:2] for lookup and id_pc[IDX_W+1:2] for update, IDX_W = log2(ENTRIES).
REQ-020 pred_taken SHALL be counter[1] of the indexed entry when if_valid & init_done, else 0.
REQ-021 Resolve event = id_valid & ~id_stall & init_done.
REQ-022 On resolve with id_ctrl[1]=1: entry increments if PC_sel=1 (saturate at 3), decrements if PC_sel=0 (saturate at 0), written at next edge.
REQ-023 Non-branch instructions (id_ctrl[1]=0) SHALL NOT update the table.
REQ-024 On resolve, mispredict SHALL be 1 the following cycle iff PC_sel != id_pred_taken, including non-branch with id_pred_taken=1; redirect_taken <= PC_sel.
REQ-025 mispredict and redirect_taken SHALL be 0 in any cycle following a non-resolve cycle.
REQ-026 Lookup and update to the same index in one cycle: lookup returns the pre-update value (no bypass).
REQ-027 FSM states INIT, RUN; INIT writes 2'b01 (weakly not-taken) to entry k on cycle k, k = 0..ENTRIES-1, then RUN; RUN is absorbing until rst.

Reset
REQ-028 rst SHALL force INIT with sweep index 0, init_done=0, mispredict=0, redirect_taken=0 at the next edge.
REQ-029 rst asserted mid-sweep or in RUN SHALL restart the sweep from index 0; init_done rises ENTRIES cycles after rst deasserts.
REQ-030 During INIT, resolve events are ignored and pred_taken=0.

Configuration
REQ-031 Macro BP_STATS_EN: when defined, adds outputs stat_branches and stat_mispredicts (32 bits each), incremented on resolve with id_ctrl[1]=1 and on each mispredict respectively, saturating at all-ones, cleared by rst.
REQ-032 Without BP_STATS_EN those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-033 Shared package dlx_bp_pkg SHALL hold counter encodings (SNT=0, WNT=1, WT=2, ST=3), the id_ctrl bit positions and the FSM state type.
REQ-034 Sub-module bp_counter_table SHALL hold the counter array: one async read port, one sync write port, and the saturating update.

Verification
REQ-035 rst for 1 cycle, ENTRIES=64 -> init_done low for exactly 64 cycles, then high; pred_taken=0 for every PC probed.
REQ-036 beq at id_pc=0x40, id_cmp=1, id_pred_taken=0, twice -> mispredict pulses both times; lookup at 0x40 then returns pred_taken=1 (counter 3).
REQ-037 bne at 0x80, id_cmp=1, id_pred_taken=0 -> PC_sel=0, no mispredict, entry saturates at 0 after two updates.
REQ-038 id_ctrl=2'b00, id_pred_taken=1 -> mispredict=1, redirect_taken=0; table unchanged.
REQ-039 Valid branch with id_stall=1 for 3 cycles -> no update, no mispredict until stall drops; then exactly one update.
REQ-040 rst asserted at sweep index 30 -> sweep restarts at 0; with BP_STATS_EN, stats cleared to 0.
